dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Multi-cycle data-memory request controller between the MEM stage and a real
//  (non-magic) data memory port with a resp handshake. It takes the MEM stage's
//  address, masks and write data, and drives a held read/write request until
//  mem_resp. It returns the load word to the MEM stage and stalls the pipeline
//  while a transaction is outstanding. One clock; reset is asynchronous and active-low.
// PARAMETERS
//  TIMEOUT   256  cycles in REQ before forced completion with err; 0 = never time out
//  CNT_W     16   width of the saturating stall-cycle performance counter
// PORTS
//  clk           in   1      clock; all state updates on rising edge
//  rst           in   1      asynchronous, active-low reset (0 = reset)
//  req_valid     in   1      MEM stage holds a valid instruction
//  dmem_addr     in   32     byte address from the MEM stage
//  rmask         in   4      byte read mask; nonzero = load
//  wmask         in   4      byte write mask; nonzero = store (takes priority over rmask)
//  dmem_wdata    in   32     lane-shifted store data
//  pipe_adv      in   1      whole pipeline advances this cycle (no other stall source)
//  dmem_rdata    out  32     load word returned to the MEM stage (held)
//  dmem_stall    out  1      hold the pipeline; transaction not yet complete
//  err           out  1      one-cycle pulse on timeout completion
//  stall_cnt     out  CNT_W  saturating count of cycles with dmem_stall=1
//  mem_read      out  1      memory read request
//  mem_write     out  1      memory write request
//  mem_addr      out  32     word-aligned address {dmem_addr[31:2],2'b00}
//  mem_wmask     out  4      byte enables for the write
//  mem_wdata     out  32     write data
//  mem_resp      in   1      memory has completed the current request
//  mem_rdata     in   32     read data, valid in the mem_resp cycle
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE. All outputs are 0, including stall_cnt and
//   dmem_rdata. An in-flight memory transaction is abandoned and mem_resp is ignored.
//  Request: active = req_valid & (|rmask | |wmask).
//  States:
//   IDLE: if active, latch addr/wmask/wdata and the kind (write if |wmask, else read).
//    Go to REQ. dmem_stall=1 combinationally in that same cycle.
//    If not active, dmem_stall=0.
//   REQ: mem_read or mem_write=1. mem_addr, mem_wmask and mem_wdata come from the
//    latches and are held stable until mem_resp. dmem_stall=1.
//    On mem_resp: capture mem_rdata into dmem_rdata (reads only; writes leave it
//    unchanged). Drop the request and go to DONE.
//    On timeout (TIMEOUT cycles in REQ without resp): dmem_rdata=0, err pulses 1,
//    go to DONE.
//   DONE: dmem_stall=0. dmem_rdata is held. No new request is issued, even though
//    active is still 1 for the same instruction.
//    pipe_adv=1 goes to IDLE. pipe_adv=0 stays in DONE (external freeze, no reissue).
//  Minimum load latency: the request is seen in cycle 0, mem_read is high from cycle 1,
//   and resp in cycle 1 gives DONE in cycle 2. So the MEM stage stalls for exactly 2 cycles.
//  mem_read and mem_write are never 1 simultaneously. Each is 0 outside REQ.
//  mem_resp in IDLE or DONE is ignored.
//  The timeout counter clears on REQ entry.
//  stall_cnt increments on every cycle with dmem_stall=1 and saturates at all-ones.
//  Back-to-back requests: DONE -> IDLE -> REQ. The next instruction's request
//   starts in the IDLE cycle following pipe_adv.
//  The inputs are not required to stay stable after the IDLE capture cycle.
//   Only the latched copies are used.
// TESTING
//  lw at 0x1000, resp after 3 cycles with 0xDEADBEEF -> mem_addr=0x1000, mem_read
//   high 3 cycles, then dmem_rdata=0xDEADBEEF, stall low in DONE.
//  sb at 0x2003, wmask=4'b1000, wdata=0xAB000000 -> mem_write=1, mem_addr=0x2000,
//   mem_wmask=4'b1000; dmem_rdata unchanged.
//  Load completes while pipe_adv=0 for 4 cycles -> stays in DONE, no second
//   mem_read, dmem_rdata stable; advances on pipe_adv.
//  No resp, TIMEOUT=8 -> after 8 REQ cycles err=1 for 1 cycle, dmem_rdata=0, stall drops.
//  rst driven low mid-REQ -> all outputs 0 immediately (async); late mem_resp after
//   release is ignored.
//  Two back-to-back lw with immediate resp -> each stalls exactly 2 cycles;
//   stall_cnt=4 afterwards.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: latches a load/store and holds it on the
// memory port until mem_resp (or timeout), stalling the pipeline meanwhile.
module dmem_access_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [31:0]      dmem_addr,
    input  logic [3:0]       rmask,
    input  logic [3:0]       wmask,
    input  logic [31:0]      dmem_wdata,
    input  logic             pipe_adv,
    output logic [31:0]      dmem_rdata,
    output logic             dmem_stall,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_wmask,
    output logic [31:0]      mem_wdata,
    input  logic             mem_resp,
    input  logic [31:0]      mem_rdata
);
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    typedef struct packed {
        logic [29:0] word;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        is_wr;
    } req_t;

    state_t          state;
    req_t            lat;
    logic [TO_W-1:0] to_cnt;
    logic            active;
    logic            timed_out;

    assign active    = req_valid & ((|rmask) | (|wmask));
    assign timed_out = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    // Gated by rst so a held request cannot raise stall while in reset.
    assign dmem_stall = rst & (((state == IDLE) & active) | (state == REQ));

    assign mem_addr  = {lat.word, 2'b00};
    assign mem_wmask = lat.wmask;
    assign mem_wdata = lat.wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lat        <= '0;
            to_cnt     <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            dmem_rdata <= '0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (active) begin
                        lat.word  <= dmem_addr[31:2];
                        lat.wmask <= wmask;
                        lat.wdata <= dmem_wdata;
                        lat.is_wr <= |wmask;
                        to_cnt    <= '0;
                        mem_read  <= ~(|wmask);
                        mem_write <= |wmask;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // A response in the final allowed cycle wins over the timeout.
                    if (mem_resp) begin
                        if (!lat.is_wr) dmem_rdata <= mem_rdata;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= DONE;
                    end else if (timed_out) begin
                        dmem_rdata <= '0;
                        err        <= 1'b1;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        state      <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (pipe_adv) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (dmem_stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized transaction-level check of dmem_access_ctrl against a
// per-transaction timeline model (issue cycle, REQ length, DONE hold).
module tb_dmem_access_ctrl;
    localparam int TO    = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic [31:0]      dmem_addr = '0;
    logic [3:0]       rmask = '0;
    logic [3:0]       wmask = '0;
    logic [31:0]      dmem_wdata = '0;
    logic             pipe_adv = 1'b0;
    logic [31:0]      dmem_rdata;
    logic             dmem_stall;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      mem_addr;
    logic [3:0]       mem_wmask;
    logic [31:0]      mem_wdata;
    logic             mem_resp = 1'b0;
    logic [31:0]      mem_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: last returned load word and stall-cycle count.
    logic [31:0] rdata_m = '0;
    int          cnt_m   = 0;

    dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .dmem_addr(dmem_addr),
        .rmask(rmask), .wmask(wmask), .dmem_wdata(dmem_wdata), .pipe_adv(pipe_adv),
        .dmem_rdata(dmem_rdata), .dmem_stall(dmem_stall), .err(err),
        .stall_cnt(stall_cnt), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            rmask     = '0;
            wmask     = '0;
            mem_resp  = 1'($urandom_range(0, 1));
            pipe_adv  = 1'($urandom_range(0, 1));
            dmem_addr = $urandom;
            @(negedge clk);
            chk("idle_stall", dmem_stall, 0);
            chk("idle_rd", mem_read, 0);
            chk("idle_wr", mem_write, 0);
            chk("idle_rdata", dmem_rdata, rdata_m);
            next_cycle();
        end
    endtask

    // k: REQ cycle (0-based) in which mem_resp is given; k >= TO means never.
    task automatic do_txn(input bit is_wr, input logic [31:0] addr, input logic [3:0] msk,
                          input logic [31:0] wd, input int k, input int frz);
        logic [3:0]  wm;
        logic [3:0]  rm;
        logic [31:0] rd;
        bit          to;
        int          len;
        wm  = is_wr ? msk : 4'h0;
        rm  = is_wr ? 4'($urandom_range(0, 15)) : msk;
        to  = (k >= TO);
        len = to ? TO : k + 1;
        rd  = '0;

        req_valid = 1'b1; dmem_addr = addr; rmask = rm; wmask = wm; dmem_wdata = wd;
        pipe_adv  = 1'($urandom_range(0, 1));
        mem_resp  = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("issue_stall", dmem_stall, 1);
        chk("issue_rd", mem_read, 0);
        chk("issue_wr", mem_write, 0);
        next_cycle();

        for (int i = 0; i < len; i++) begin
            dmem_addr  = $urandom;
            dmem_wdata = $urandom;
            rmask      = 4'($urandom_range(0, 15));
            wmask      = 4'($urandom_range(0, 15));
            pipe_adv   = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            mem_resp   = (i == k);
            if (i == k) rd = mem_rdata;
            @(negedge clk);
            chk("req_rd", mem_read, !is_wr);
            chk("req_wr", mem_write, is_wr);
            chk("req_addr", mem_addr, {addr[31:2], 2'b00});
            chk("req_wmask", mem_wmask, wm);
            chk("req_wdata", mem_wdata, wd);
            chk("req_stall", dmem_stall, 1);
            chk("req_err", err, 0);
            next_cycle();
        end

        if (to) rdata_m = '0;
        else if (!is_wr) rdata_m = rd;
        cnt_m = (cnt_m + 1 + len > CMAX) ? CMAX : cnt_m + 1 + len;

        // Same instruction still presented: must not be reissued while in DONE.
        req_valid = 1'b1; dmem_addr = addr; rmask = rm; wmask = wm; dmem_wdata = wd;
        for (int j = 0; j <= frz; j++) begin
            pipe_adv  = (j == frz);
            mem_resp  = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(negedge clk);
            chk("done_stall", dmem_stall, 0);
            chk("done_rd", mem_read, 0);
            chk("done_wr", mem_write, 0);
            chk("done_rdata", dmem_rdata, rdata_m);
            chk("done_err", err, (to && j == 0));
            if (j == 0) chk("stall_cnt", stall_cnt, cnt_m);
            next_cycle();
        end
        mem_resp = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, dmem_rdata, 0);
        chk({tag, "_stall"}, dmem_stall, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_cnt"}, stall_cnt, 0);
        chk({tag, "_rd"}, mem_read, 0);
        chk({tag, "_wr"}, mem_write, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wmask"}, mem_wmask, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        // Reset with an active request held on the inputs.
        req_valid = 1'b1; rmask = 4'hF; dmem_addr = 32'h1234; mem_resp = 1'b1;
        #1;
        chk_all_zero("rst0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst1");
        rst = 1'b1;
        req_valid = 1'b0; rmask = '0; mem_resp = 1'b0;
        next_cycle();

        // Load a known value so the mid-REQ reset has something to clear.
        do_txn(1'b0, 32'h0000_0040, 4'hF, 32'h0, 1, 0);

        // Async reset in the middle of REQ.
        req_valid = 1'b1; dmem_addr = 32'h0000_3000; rmask = 4'hF; wmask = '0;
        next_cycle();
        @(negedge clk);
        chk("mid_rd_pre", mem_read, 1);
        #2 rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        rdata_m = '0;
        cnt_m   = 0;
        req_valid = 1'b0; rmask = '0;
        mem_resp = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_resp_rd", mem_read, 0);
            chk("late_resp_rdata", dmem_rdata, 0);
            chk("late_resp_stall", dmem_stall, 0);
            next_cycle();
        end
        mem_resp = 1'b0;

        // Two back-to-back loads with immediate response: 2 stall cycles each.
        do_txn(1'b0, 32'h0000_0100, 4'hF, 32'h0, 0, 0);
        do_txn(1'b0, 32'h0000_0104, 4'hF, 32'h0, 0, 0);
        chk("b2b_cnt", stall_cnt, 4);

        do_txn(1'b0, 32'h0000_1000, 4'hF, 32'h0, 2, 0);
        do_txn(1'b1, 32'h0000_2003, 4'b1000, 32'hAB00_0000, 1, 1);
        do_txn(1'b0, 32'h0000_0800, 4'hF, 32'h0, 1, 4);
        do_txn(1'b0, 32'h0000_0900, 4'hF, 32'h0, 50, 1);
        do_txn(1'b0, 32'h0000_0A00, 4'hF, 32'h0, TO - 1, 0);
        idle_cycles(2);

        for (int t = 0; t < 40; t++) begin
            int k;
            k = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 4);
            do_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)), $urandom,
                   k, $urandom_range(0, 3));
            idle_cycles($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
